huff_bit_chunker: RTL and testbench

//   Upstream feeder for the Huffman decode buffer. Accepts packed bitstream words (MSB = first bit)

---
 rtl/huff_bit_chunker_pkg.sv | 46 ++++
 rtl/huff_bit_chunker_if.sv | 33 +++
 rtl/huff_bit_chunker.sv | 90 +++++++++
 tb/tb_huff_bit_chunker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/huff_bit_chunker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huff_bit_chunker_pkg
//  Description : Widths, FSM encoding and chunk-slicing helpers that the
//                chunker and the Huffman decode buffer both use.
//  Revision    : 1.0 - initial release
// ============================================================================
package huff_bit_chunker_pkg;

    localparam int WORD_W  = 8;
    localparam int CHUNK_W = 4;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CHUNK_CNT = CNT_W'(CHUNK_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TAIL   = 2'd2
    } state_e;

    // A last word's bit count of 0, or anything above WORD_W, means a full word.
    function automatic logic [CNT_W-1:0] clamp_nbits(input logic [CNT_W-1:0] nbits);
        if (nbits == '0 || nbits > WORD_CNT) return WORD_CNT;
        return nbits;
    endfunction

    function automatic logic [LEN_W-1:0] chunk_len(input logic [CNT_W-1:0] bits_left);
        if (bits_left > CHUNK_CNT) return LEN_W'(CHUNK_W);
        return bits_left[LEN_W-1:0];
    endfunction

    // Top len bits of the left-aligned word, right-aligned; len=0 yields 0.
    function automatic logic [CHUNK_W-1:0] extract(input logic [WORD_W-1:0] word,
                                                   input logic [LEN_W-1:0]  len);
        logic [CHUNK_W-1:0] top;
        logic [LEN_W:0]     sh;
        top = word[WORD_W-1 -: CHUNK_W];
        sh  = (LEN_W+1)'(CHUNK_W) - {1'b0, len};
        return top >> sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huff_bit_chunker_if.sv
`default_nettype none
// ============================================================================
//  Module      : huff_bit_chunker_if
//  Description : Word-stream input and chunk output handshakes of the chunker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface huff_bit_chunker_if;
    import huff_bit_chunker_pkg::*;

    logic [WORD_W-1:0]  s_data;
    logic               s_valid;
    logic               s_last;
    logic [CNT_W-1:0]   s_nbits;
    logic               s_ready;
    logic [CHUNK_W-1:0] out_bits;
    logic [LEN_W-1:0]   out_len;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               frame_done;

    modport master (
        output s_data, s_valid, s_last, s_nbits, out_ready,
        input  s_ready, out_bits, out_len, out_valid, out_last, frame_done
    );

    modport slave (
        input  s_data, s_valid, s_last, s_nbits, out_ready,
        output s_ready, out_bits, out_len, out_valid, out_last, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/huff_bit_chunker.sv
`default_nettype none
// ============================================================================
//  Module      : huff_bit_chunker
//  Description : Slices packed MSB-first words into right-aligned chunks of up
//                to CHUNK_W bits for the Huffman decode buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module huff_bit_chunker
    import huff_bit_chunker_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           reset,
    huff_bit_chunker_if.slave   bus
);

    state_e             state_q,      state_d;
    logic [WORD_W-1:0]  word_q,       word_d;
    logic [CNT_W-1:0]   bits_left_q,  bits_left_d;
    logic [CHUNK_W-1:0] out_bits_q,   out_bits_d;
    logic [LEN_W-1:0]   out_len_q,    out_len_d;
    logic               out_valid_q,  out_valid_d;
    logic               out_last_q,   out_last_d;
    logic               frame_done_q, frame_done_d;

    logic               w_consume;
    logic               w_accept;
    logic               w_s_ready;

    // s_ready sees out_ready combinationally so the final chunk of a word and
    // the next word's acceptance share one cycle.
    always_comb begin
        w_consume   = out_valid_q && bus.out_ready;
        w_s_ready   = (state_q == ST_IDLE) || (w_consume && (bits_left_q <= CHUNK_CNT));
        w_accept    = bus.s_valid && w_s_ready;

        state_d     = state_q;
        word_d      = word_q;
        bits_left_d = bits_left_q;

        if (w_consume) begin
            word_d      = word_q << out_len_q;
            bits_left_d = bits_left_q - CNT_W'(out_len_q);
            if (bits_left_d == '0) state_d = ST_IDLE;
        end

        if (w_accept) begin
            word_d      = bus.s_data;
            bits_left_d = bus.s_last ? clamp_nbits(bus.s_nbits) : WORD_CNT;
            state_d     = bus.s_last ? ST_TAIL : ST_ACTIVE;
        end

        // Outputs are precomputed from next state so they are registered.
        out_len_d    = chunk_len(bits_left_d);
        out_bits_d   = extract(word_d, out_len_d);
        out_valid_d  = (state_d != ST_IDLE);
        out_last_d   = (state_d == ST_TAIL) && (bits_left_d <= CHUNK_CNT);
        frame_done_d = w_consume && out_last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            bits_left_q  <= '0;
            out_bits_q   <= '0;
            out_len_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            bits_left_q  <= bits_left_d;
            out_bits_q   <= out_bits_d;
            out_len_q    <= out_len_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.out_bits   = out_bits_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_huff_bit_chunker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huff_bit_chunker
//  Description : Directed and random stimulus against a chunk-list reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_bit_chunker;

    typedef struct {
        logic [3:0] bits;
        logic [2:0] len;
        logic       last;
    } chunk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    chunk_t q[$];
    logic exp_fd = 1'b0;

    huff_bit_chunker_if bus ();

    huff_bit_chunker dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the word's valid bits cut into 4-bit pieces from the MSB end.
    task automatic push_word(input logic [7:0] d, input logic l, input logic [3:0] nb);
        int n, pos, len;
        chunk_t c;
        n   = (l && nb != 0 && nb <= 8) ? int'(nb) : 8;
        pos = 0;
        while (pos < n) begin
            len    = (n - pos < 4) ? n - pos : 4;
            c.bits = 4'((int'(d) >> (8 - pos - len)) & ((1 << len) - 1));
            c.len  = 3'(len);
            c.last = l && (pos + len == n);
            q.push_back(c);
            pos += len;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        if (q.size() != 0) begin
            chk("out_bits", 32'(bus.out_bits), 32'(q[0].bits));
            chk("out_len",  32'(bus.out_len),  32'(q[0].len));
            chk("out_last", 32'(bus.out_last), 32'(q[0].last));
        end else begin
            chk("idle_bits", 32'(bus.out_bits), 32'd0);
            chk("idle_len",  32'(bus.out_len),  32'd0);
            chk("idle_last", 32'(bus.out_last), 32'd0);
        end
    endtask

    // One clock: check outputs, drive inputs, predict the edge, advance.
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic l, input logic [3:0] nb, input logic rdy);
        logic exp_rdy, cons;
        check_outputs();
        rst = r; bus.s_valid = v; bus.s_data = d; bus.s_last = l;
        bus.s_nbits = nb; bus.out_ready = rdy;
        #1;
        exp_rdy = (q.size() == 0) || (rdy && q.size() == 1);
        cons    = (q.size() != 0) && rdy;
        if (r) begin
            q.delete();
            exp_fd = 1'b0;
        end else begin
            chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
            exp_fd = cons && q[0].last;
            if (cons) void'(q.pop_front());
            if (v && exp_rdy) push_word(d, l, nb);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.s_nbits = '0;   bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_len",   32'(bus.out_len),   32'd0);
        chk("rst_fd",    32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Full non-last word
        step(0, 1, 8'hB4, 0, 4'd0, 1);
        chk("t1_c1", 32'(bus.out_bits), 32'hB);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        chk("t1_c2", 32'(bus.out_bits), 32'h4);
        step(0, 0, 8'h00, 0, 4'd0, 1);

        // Short last word: single 3-bit chunk, then a frame_done pulse
        step(0, 1, 8'hA0, 1, 4'd3, 1);
        chk("t2_bits", 32'(bus.out_bits), 32'b0101);
        chk("t2_len",  32'(bus.out_len),  32'd3);
        chk("t2_last", 32'(bus.out_last), 32'd1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        chk("t2_fd", 32'(bus.frame_done), 32'd1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        chk("t2_fd_off", 32'(bus.frame_done), 32'd0);

        // 6-bit last word, then nbits=0 meaning a full last word
        step(0, 1, 8'hFC, 1, 4'd6, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        chk("t3_tail", 32'(bus.out_bits), 32'b0011);
        step(0, 1, 8'h5A, 1, 4'd0, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        step(0, 1, 8'hFF, 1, 4'd12, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);

        // Back-to-back words with zero-bubble refill
        step(0, 1, 8'h12, 0, 4'd0, 1);
        step(0, 1, 8'h34, 0, 4'd0, 1);
        step(0, 1, 8'h34, 0, 4'd0, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        step(0, 0, 8'h00, 0, 4'd0, 1);

        // Backpressure holds the first chunk
        step(0, 1, 8'hC3, 0, 4'd0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h77, 0, 4'd0, 0);
        chk("t5_hold", 32'(bus.out_bits), 32'hC);
        step(0, 0, 8'h00, 0, 4'd0, 1);
        chk("t5_rel", 32'(bus.out_bits), 32'h3);
        step(0, 0, 8'h00, 0, 4'd0, 1);

        // Reset mid-word discards it
        step(0, 1, 8'h9E, 0, 4'd0, 1);
        step(1, 0, 8'h00, 0, 4'd0, 1);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        step(0, 1, 8'h5A, 1, 4'd0, 1);
        chk("t6_first", 32'(bus.out_bits), 32'h5);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] rv;
            rv = $urandom;
            step(logic'(rv[11:6] == 6'd0), logic'(rv[0] | rv[1]), 8'($urandom),
                 logic'(rv[3:2] == 2'd0), 4'($urandom_range(0, 15)), logic'(rv[4] | rv[5]));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 4'd0, 1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
